ntt_coef_loader: RTL
====================

// Module: ntt_coef_loader
// PURPOSE
// - Upstream stage of the NTT core: accepts a stream of raw polynomial coefficients,
//   reduces each one mod Q, and writes it into the 4-bank coefficient RAM.
// - Placement uses the same conflict-free (bank, offset) mapping the butterfly datapath
//   reads with, so no reordering is needed before the first NTT stage.
// - Pulses done after the last write; the top level uses it to raise ctrl start.
// PARAMETERS
// - LOG_N       11     log2 of the polynomial length; N = 1<<LOG_N coefficients per load
// - IN_W        16     raw input sample width
// - DW          14     reduced coefficient width (matches `datawidth)
// - Q           12289  modulus
// PORTS
// - clk         in   1        system clock, rising edge
// - rstn        in   1        asynchronous active-low reset
// - load_start  in   1        1-cycle pulse; begins a load of N coefficients
// - in_valid    in   1        upstream sample valid
// - in_ready    out  1        loader accepts the sample this cycle
// - in_data     in   IN_W     raw coefficient, unsigned
// - mem_wen     out  1        coefficient RAM write enable
// - mem_bank    out  2        target bank 0..3
// - mem_addr    out  LOG_N-2  word offset within the bank
// - mem_wdata   out  DW       reduced coefficient, 0..Q-1
// - busy        out  1        high from load_start accept until done
// - done        out  1        1-cycle pulse after the final write
// BEHAVIOUR
// - Reset values: in_ready=0, mem_wen=0, mem_bank=0, mem_addr=0, mem_wdata=0, busy=0, done=0.
// - FSM states:
//   - IDLE  -(load_start)->  LOAD.
//   - LOAD  -(N samples accepted)->  DRAIN.
//   - DRAIN -(pipeline empty)->  IDLE, pulsing done in the same transition.
// - Handshake: a transfer occurs when in_valid && in_ready.
//   - in_ready = (state==LOAD) && (acc_cnt < N), decoded combinationally from registered state.
//   - in_data is not sampled when there is no transfer.
// - acc_cnt (LOG_N+1 bits): cleared on load_start, +1 per transfer. It is the linear index a.
// - Pipeline: 2 register stages; a transfer in cycle t gives mem_wen=1 in cycle t+2.
//   - S1 registers in_data and index a. It also registers the compare flags in_data >= k*Q for k=1..5.
//   - S2 subtracts the largest k*Q flagged, then drives the RAM outputs.
//   - Result is always < Q. Bubbles propagate as mem_wen=0.
// - Mapping of index a, with LOG_N=11:
//   - mem_bank = (a[1:0]+a[3:2]+a[5:4]+a[7:6]+a[9:8]+{1'b0,a[10]}) mod 4.
//   - mem_addr = a[10:2].
//   - For general LOG_N, sum every 2-bit digit of a and zero-pad the top digit.
// - done: asserted exactly 1 cycle, in the cycle after the N-th mem_wen. busy falls in that same cycle.
// - load_start while busy: ignored; the current load is unaffected.
// - load_start in the same cycle as done: ignored; a new load needs a fresh pulse.
// - in_valid outside LOAD: ignored. in_ready stays 0 and nothing is written.
// - Stalls: in_valid low mid-load pauses acc_cnt. There is no timeout and nothing is written.
// - The write path never back-pressures; the RAM always accepts.
// - Async reset mid-load: immediate return to IDLE and all outputs take reset values.
//   - Partially written RAM content is not cleared.
// CONFIGURATION
// - NTT_LOADER_BITREV_EN defined:
//   - the mapping uses bitrev_LOG_N(a) in place of a, so natural-order input lands in
//     bit-reversed placement;
//   - latency, handshake and the done timing are unchanged.
// - Not defined: the mapping uses a directly (natural placement).
// TESTING
// - Reset, then load_start, then in_valid held high with data 0..2047:
//   - 2048 writes on consecutive cycles;
//   - first mem_wen 2 cycles after the first transfer;
//   - done 1 cycle after the last write.
// - Mapping (BITREV off):
//   - a=0 -> bank0/addr0;  a=3 -> bank3/addr0;  a=5 -> bank2/addr1;
//   - a=2047 -> bank (3+3+3+3+3+1)%4=0 / addr511.
// - Reduction:
//   - in_data 12288 -> 12288;  12289 -> 0;  24578 -> 0;  65535 -> 4090.
// - Random in_valid gaps (about 40% duty):
//   - exactly 2048 writes, every one 2 cycles after its transfer;
//   - all (bank, addr) pairs unique; in_ready=0 after the 2048th transfer.
// - Extra load_start pulses during LOAD and DRAIN:
//   - no effect; acc_cnt is not cleared; exactly one done pulse.
// - rstn low at transfer 700: all outputs 0 the same cycle. After release, a new load_start
//   restarts at a=0.
// - BITREV_EN build: a=1 maps as a'=1024 -> bank1/addr256.

Source files
------------

// File: rtl/ntt_coef_loader_if.sv
// ntt_coef_loader_if
//   Groups the coefficient loader's upstream sample handshake and the
//   coefficient-RAM write bus.
//   master : upstream/environment side (drives samples, observes RAM writes)
//   slave  : loader side (accepts samples, drives RAM writes)
// Signals
//   in_valid  upstream sample valid
//   in_ready  loader accepts the sample this cycle
//   in_data   raw unsigned coefficient, IN_W bits
//   mem_wen   coefficient RAM write enable
//   mem_bank  target bank 0..3
//   mem_addr  word offset within the bank, LOG_N-2 bits
//   mem_wdata reduced coefficient, DW bits
interface ntt_coef_loader_if #(
  parameter int LOG_N = 11,
  parameter int IN_W  = 16,
  parameter int DW    = 14
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             mem_wen;
  logic [1:0]       mem_bank;
  logic [LOG_N-3:0] mem_addr;
  logic [DW-1:0]    mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_wen, mem_bank, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_wen, mem_bank, mem_addr, mem_wdata
  );
endinterface

// File: rtl/ntt_coef_loader.sv
// ntt_coef_loader
//   Accepts N = 1<<LOG_N raw coefficients, reduces each mod Q and writes it
//   into the 4-bank coefficient RAM using the butterfly's conflict-free
//   (bank, offset) placement. Pulses done the cycle after the final write.
// Ports
//   clk        system clock, rising edge
//   rstn       asynchronous active-low reset
//   load_start 1-cycle pulse starting a load (ignored while busy / on done)
//   busy       high while a load is in progress
//   done       1-cycle pulse after the last RAM write
//   bus        ntt_coef_loader_if.slave: sample handshake + RAM write bus
// Build option
//   NTT_LOADER_BITREV_EN : place coefficient a at the slot of bitrev(a)
//   instead of a. Latency, handshake and done timing are identical.
//
// state | meaning
// IDLE  | waiting for load_start
// LOAD  | accepting samples until N have been transferred
// DRAIN | last sample in the pipeline; leave when its write retires
module ntt_coef_loader #(
  parameter int LOG_N = 11,
  parameter int IN_W  = 16,
  parameter int DW    = 14,
  parameter int Q     = 12289
) (
  input  logic clk,
  input  logic rstn,
  input  logic load_start,
  output logic busy,
  output logic done,
  ntt_coef_loader_if.slave bus
);
  localparam logic [LOG_N:0] N_CNT    = (LOG_N+1)'(1 << LOG_N);
  localparam logic [LOG_N:0] LAST_CNT = (LOG_N+1)'((1 << LOG_N) - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [LOG_N:0]   acc_cnt;
  logic             done_q;
  logic             ready, xfer, start_ok, last_xfer;

  logic             s1_valid;
  logic [IN_W-1:0]  s1_data;
  logic [LOG_N-1:0] s1_idx;
  logic [4:0]       s1_ge;
  logic [4:0]       ge_d;
  logic [31:0]      din32;

  logic [31:0]      data_ext, sub_val;
  logic [LOG_N-1:0] map_idx;
  logic [DW-1:0]    wdata_d;

  logic             wen_q;
  logic [1:0]       bank_q;
  logic [LOG_N-3:0] addr_q;
  logic [DW-1:0]    wdata_q;

  // Bank = sum of all 2-bit digits of the index mod 4; odd LOG_N leaves a
  // 1-bit top digit, which the zero pad turns into a 2-bit one.
  function automatic logic [1:0] bank_of(input logic [LOG_N-1:0] a);
    logic [LOG_N:0] p;
    logic [1:0]     s;
    p = {1'b0, a};
    s = '0;
    for (int i = 0; i < LOG_N; i += 2) s = s + p[i +: 2];
    return s;
  endfunction

`ifdef NTT_LOADER_BITREV_EN
  function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] a);
    logic [LOG_N-1:0] r;
    for (int i = 0; i < LOG_N; i++) r[i] = a[LOG_N-1-i];
    return r;
  endfunction
`endif

  assign ready        = (state_q == LOAD) && (acc_cnt < N_CNT);
  assign xfer         = bus.in_valid && ready;
  // done_q blocks a start pulse that coincides with the done pulse
  assign start_ok     = load_start && (state_q == IDLE) && !done_q;
  assign last_xfer    = xfer && (acc_cnt == LAST_CNT);
  assign bus.in_ready = ready;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = LOAD;
      LOAD:    if (last_xfer) state_d = DRAIN;
      // no transfers in DRAIN, so an empty S1 with S2 writing means the
      // final write is on the bus this cycle
      DRAIN:   if (wen_q && !s1_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      acc_cnt <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == DRAIN) && (state_d == IDLE);
      if (start_ok)  acc_cnt <= '0;
      else if (xfer) acc_cnt <= acc_cnt + 1'b1;
    end
  end

  // S1: capture sample, its index and the in_data >= k*Q flags (k = 1..5)
  assign din32 = 32'(bus.in_data);
  always_comb begin
    ge_d = '0;
    for (int k = 1; k <= 5; k++) ge_d[k-1] = (din32 >= 32'(k * Q));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_idx   <= '0;
      s1_ge    <= '0;
    end else begin
      s1_valid <= xfer;
      if (xfer) begin
        s1_data <= bus.in_data;
        s1_idx  <= acc_cnt[LOG_N-1:0];
        s1_ge   <= ge_d;
      end
    end
  end

  // S2: flags are monotone, so the highest set flag selects the multiple
  assign data_ext = 32'(s1_data);
  always_comb begin
    sub_val = '0;
    for (int k = 1; k <= 5; k++) if (s1_ge[k-1]) sub_val = 32'(k * Q);
  end
  assign wdata_d = DW'(data_ext - sub_val);

`ifdef NTT_LOADER_BITREV_EN
  assign map_idx = bitrev(s1_idx);
`else
  assign map_idx = s1_idx;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wen_q   <= 1'b0;
      bank_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      wen_q <= s1_valid;
      if (s1_valid) begin
        bank_q  <= bank_of(map_idx);
        addr_q  <= map_idx[LOG_N-1:2];
        wdata_q <= wdata_d;
      end
    end
  end

  assign bus.mem_wen   = wen_q;
  assign bus.mem_bank  = bank_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
endmodule
